// File: rtl/wam_pkg.sv
// Shared types and difficulty tables for the whack-a-mole round engine.
package wam_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } state_e;

  localparam int unsigned CNT_W     = 8;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [CNT_W-1:0] spawn_ticks(input logic [1:0] d);
    logic [CNT_W-1:0] r;
    case (d)
      2'd0:    r = 8'd50;
      2'd1:    r = 8'd30;
      2'd2:    r = 8'd15;
      default: r = 8'd8;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] life_ticks(input logic [1:0] d);
    logic [CNT_W-1:0] r;
    case (d)
      2'd0:    r = 8'd150;
      2'd1:    r = 8'd100;
      2'd2:    r = 8'd60;
      default: r = 8'd35;
    endcase
    return r;
  endfunction

  function automatic int unsigned max_active(input logic [1:0] d);
    return 32'(d) + 32'd1;
  endfunction

  function automatic logic [1:0] points(input logic [1:0] d);
    logic [1:0] r;
    case (d)
      2'd0, 2'd1: r = 2'd1;
      2'd2:       r = 2'd2;
      default:    r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/wam_mole_slot.sv
// One hole: lifetime countdown, hit on tap edge, expiry when the count runs out.
module wam_mole_slot
  import wam_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] life,
  input  logic             tick,
  input  logic             tap_e,
  output logic             active,
  output logic             hit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign active = (cnt_q != '0);
  assign hit    = active & tap_e;
  // A hit on the final tick wins; the mole is not counted as missed.
  assign expire = active & tick & ~hit & (cnt_q == CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                 cnt_d = '0;
    else if (load)             cnt_d = life;
    else if (hit || expire)    cnt_d = '0;
    else if (active && tick)   cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wam_round_engine.sv
// Whack-a-mole round engine: prescaler, LFSR spawner, mole slots, scoring,
// miss count, round timer and game state machine.
module wam_round_engine
  import wam_pkg::*;
#(
  parameter int unsigned N_HOLES       = 8,
  parameter int unsigned SCORE_W       = 12,
  parameter int unsigned DIV_W         = 19,
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned ROUND_SECS    = 60,
  parameter int unsigned MAX_MISS      = 10,
  parameter bit          PENALTY_EN    = 1'b0,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                                clk,
  input  logic                                clr_n,
  input  logic                                start,
  input  logic                                pause,
  input  logic [1:0]                          difficulty,
  input  logic [N_HOLES-1:0]                  tap,
  output logic [N_HOLES-1:0]                  holes,
  output logic [SCORE_W-1:0]                  score,
  output logic [$clog2(MAX_MISS+1)-1:0]       misses,
  output logic [$clog2(ROUND_SECS+1)-1:0]     time_left,
  output logic                                game_over,
  output logic                                playing
);

  localparam int unsigned TIME_W = $clog2(ROUND_SECS + 1);
  localparam int unsigned MISS_W = $clog2(MAX_MISS + 1);
  localparam int unsigned SEC_W  = $clog2(TICKS_PER_SEC + 1);
  localparam int unsigned SUM_W  = SCORE_W + 5;

  state_e               state_q, state_d;
  logic                 start_q;
  logic [N_HOLES-1:0]   tap_q;
  logic [15:0]          lfsr_q;
  logic [DIV_W-1:0]     div_q;
  logic [SEC_W-1:0]     sec_q, sec_d;
  logic [TIME_W-1:0]    time_q, time_d;
  logic [SCORE_W-1:0]   score_q, score_d, score_nx;
  logic [MISS_W-1:0]    miss_q, miss_d, miss_nx;
  logic [CNT_W-1:0]     spawn_q, spawn_d;
  logic [1:0]           diff_q, diff_d;

  logic                 start_e, in_play, tick, sec_wrap, time_up, miss_limit;
  logic                 clear, spawn_ok, cand_busy;
  logic [N_HOLES-1:0]   tap_e, tap_play, hit_v, expire_v, load_v;
  logic [CNT_W-1:0]     life_c;
  logic [SUM_W-1:0]     gain, loss, sum;
  int unsigned          cand, ma, miss_sum;

  assign start_e  = start & ~start_q;
  assign tap_e    = tap & ~tap_q;
  assign in_play  = (state_q == PLAY);
  assign tick     = in_play & (&div_q);
  assign tap_play = tap_e & {N_HOLES{in_play}};
  assign sec_wrap = tick && (sec_q == SEC_W'(TICKS_PER_SEC - 1));
  assign time_up  = sec_wrap && (time_q == TIME_W'(1));
  assign life_c   = life_ticks(diff_q);
  assign cand     = 32'(lfsr_q[3:0]) % N_HOLES;
  assign ma       = (max_active(diff_q) > N_HOLES) ? N_HOLES : max_active(diff_q);

  for (genvar g = 0; g < N_HOLES; g++) begin : g_slot
    wam_mole_slot u_slot (
      .clk    (clk),
      .clr_n  (clr_n),
      .clear  (clear),
      .load   (load_v[g]),
      .life   (life_c),
      .tick   (tick),
      .tap_e  (tap_play[g]),
      .active (holes[g]),
      .hit    (hit_v[g]),
      .expire (expire_v[g])
    );
  end

  always_comb begin
    cand_busy = 1'b0;
    load_v    = '0;
    for (int unsigned i = 0; i < N_HOLES; i++)
      if (i == cand) cand_busy = holes[i];
    spawn_ok = tick && (spawn_q == CNT_W'(1)) && !cand_busy &&
               ($unsigned($countones(holes)) < ma);
    for (int unsigned i = 0; i < N_HOLES; i++)
      load_v[i] = spawn_ok && (i == cand);
  end

  // Signed headroom: bit SUM_W-1 flags underflow, bits above SCORE_W flag overflow.
  always_comb begin
    gain = SUM_W'(int'(points(diff_q)) * $countones(hit_v));
    loss = PENALTY_EN ? SUM_W'($countones(tap_play & ~holes)) : '0;
    sum  = SUM_W'(score_q) + gain - loss;
    if (sum[SUM_W-1])                 score_nx = '0;
    else if (|sum[SUM_W-2:SCORE_W])   score_nx = '1;
    else                              score_nx = sum[SCORE_W-1:0];
    miss_sum   = 32'(miss_q) + $unsigned($countones(expire_v));
    miss_limit = (miss_sum >= MAX_MISS);
    miss_nx    = miss_limit ? MISS_W'(MAX_MISS) : MISS_W'(miss_sum);
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    time_d  = time_q;
    score_d = score_q;
    miss_d  = miss_q;
    spawn_d = spawn_q;
    diff_d  = diff_q;
    clear   = 1'b0;
    if (start_e) begin
      state_d = PLAY;
      diff_d  = difficulty;
      score_d = '0;
      miss_d  = '0;
      time_d  = TIME_W'(ROUND_SECS);
      sec_d   = '0;
      spawn_d = spawn_ticks(difficulty);
      clear   = 1'b1;
    end else begin
      case (state_q)
        PLAY: begin
          score_d = score_nx;
          miss_d  = miss_nx;
          if (tick) begin
            sec_d   = sec_wrap ? '0 : sec_q + SEC_W'(1);
            spawn_d = (spawn_q == CNT_W'(1)) ? spawn_ticks(diff_q) : spawn_q - CNT_W'(1);
          end
          if (sec_wrap) time_d = time_q - TIME_W'(1);
          if (time_up || miss_limit) begin
            state_d = OVER;
            clear   = 1'b1;
          end else if (pause) begin
            state_d = PAUSED;
          end
        end
        PAUSED:  if (!pause) state_d = PLAY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      tap_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      div_q   <= '0;
      sec_q   <= '0;
      time_q  <= '0;
      score_q <= '0;
      miss_q  <= '0;
      spawn_q <= '0;
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      tap_q   <= tap;
      lfsr_q  <= lfsr_step(lfsr_q);
      div_q   <= (state_q == PAUSED) ? div_q : div_q + DIV_W'(1);
      sec_q   <= sec_d;
      time_q  <= time_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      spawn_q <= spawn_d;
      diff_q  <= diff_d;
    end
  end

  assign score     = score_q;
  assign misses    = miss_q;
  assign time_left = time_q;
  assign game_over = (state_q == OVER);
  assign playing   = (state_q == PLAY);

endmodule

// File: tb/tb_wam_round_engine.sv
// Directed bench: short-round instance for timer/pause/reset, long-round
// 4-bit-score penalty instance for hits, expiry, miss limit and saturation.
module tb_wam_round_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       rst_a_n = 1'b0, rst_b_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0, pause_a = 1'b0, pause_b = 1'b0;
  logic [1:0] diff_a = 2'd0, diff_b = 2'd0;
  logic [7:0] tap_a = '0, tap_b = '0;

  logic [7:0]  holes_a, holes_b;
  logic [11:0] score_a;
  logic [3:0]  score_b;
  logic [1:0]  misses_a, misses_b;
  logic [1:0]  time_a;
  logic [5:0]  time_b;
  logic        over_a, over_b, play_a, play_b;

  wam_round_engine #(
    .N_HOLES(8), .SCORE_W(12), .DIV_W(2), .TICKS_PER_SEC(4),
    .ROUND_SECS(3), .MAX_MISS(3), .PENALTY_EN(1'b0), .LFSR_SEED(16'hACE1)
  ) dut_a (
    .clk(clk), .clr_n(rst_a_n), .start(start_a), .pause(pause_a),
    .difficulty(diff_a), .tap(tap_a), .holes(holes_a), .score(score_a),
    .misses(misses_a), .time_left(time_a), .game_over(over_a), .playing(play_a)
  );

  wam_round_engine #(
    .N_HOLES(8), .SCORE_W(4), .DIV_W(2), .TICKS_PER_SEC(4),
    .ROUND_SECS(60), .MAX_MISS(3), .PENALTY_EN(1'b1), .LFSR_SEED(16'hACE1)
  ) dut_b (
    .clk(clk), .clr_n(rst_b_n), .start(start_b), .pause(pause_b),
    .difficulty(diff_b), .tap(tap_b), .holes(holes_b), .score(score_b),
    .misses(misses_b), .time_left(time_b), .game_over(over_b), .playing(play_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  localparam int OP_HIT   = 0;
  localparam int OP_EMPTY = 1;
  localparam int OP_BOTH  = 2;
  localparam int LIFE3    = 35;

  typedef struct {
    int op;
    int exp_score;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_time_a(input int from, output int at);
    at = -1000;
    for (int i = 0; i < 300; i++) begin
      step();
      if (int'(time_a) != from) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_mole_b(output int k, output int j);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (holes_b != '0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("mole appears", int'(ok), 1);
    k = 0;
    j = 0;
    for (int b = 7; b >= 0; b--) begin
      if (holes_b[b])  k = b;
      if (!holes_b[b]) j = b;
    end
  endtask

  task automatic start_round_b(input logic [1:0] d);
    diff_b  = d;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
  endtask

  task automatic do_op(input int idx, input int op, input int exp);
    int k, j;
    wait_mole_b(k, j);
    if (op != OP_EMPTY) tap_b[k] = 1'b1;
    if (op != OP_HIT)   tap_b[j] = 1'b1;
    step();
    check($sformatf("sat vec %0d score", idx), int'(score_b), exp);
    if (op != OP_EMPTY) check($sformatf("sat vec %0d hole", idx), int'(holes_b[k]), 0);
    tap_b = '0;
    step();
  endtask

  initial begin
    int t0, c1, c2, c3, k, j;
    bit two_up;

    vecs = '{'{OP_HIT, 3}, '{OP_HIT, 6}, '{OP_HIT, 9}, '{OP_HIT, 12},
             '{OP_HIT, 15}, '{OP_HIT, 15}, '{OP_EMPTY, 14}, '{OP_BOTH, 15}};

    repeat (3) step();
    check("rst holes", int'(holes_a), 0);
    check("rst score", int'(score_a), 0);
    check("rst misses", int'(misses_a), 0);
    check("rst time", int'(time_a), 0);
    check("rst playing", int'(play_a), 0);
    check("rst over", int'(over_a), 0);
    check("rst lfsr", int'(dut_a.lfsr_q), 'hACE1);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    repeat (2) step();

    // Round timer, difficulty 0 (no mole can spawn in a 12-tick round).
    diff_a  = 2'd0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    t0 = cyc;
    check("start playing", int'(play_a), 1);
    check("start time", int'(time_a), 3);
    wait_time_a(3, c1);
    check("timer 3->2 value", int'(time_a), 2);
    check("timer first second length", int'((c1 - t0) >= 13 && (c1 - t0) <= 16), 1);
    wait_time_a(2, c2);
    check("timer 2->1 value", int'(time_a), 1);
    check("timer 2->1 interval", c2 - c1, 16);
    wait_time_a(1, c3);
    check("timer 1->0 value", int'(time_a), 0);
    check("timer 1->0 interval", c3 - c2, 16);
    check("timeout game_over", int'(over_a), 1);
    check("timeout playing", int'(play_a), 0);
    check("timeout holes", int'(holes_a), 0);

    // Pause freezes the timer for exactly the paused cycles; taps ignored.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("restart from over", int'(play_a), 1);
    wait_time_a(3, c1);
    repeat (2) step();
    pause_a = 1'b1;
    repeat (40) step();
    tap_a = '1;
    repeat (30) step();
    tap_a = '0;
    repeat (30) step();
    check("pause playing", int'(play_a), 0);
    check("pause time held", int'(time_a), 2);
    check("pause score held", int'(score_a), 0);
    check("pause holes", int'(holes_a), 0);
    pause_a = 1'b0;
    wait_time_a(2, c2);
    check("resume time value", int'(time_a), 1);
    check("resume interval", c2 - c1, 116);
    check("resume playing", int'(play_a), 1);

    // Single hit at difficulty 2, then a held tap must not score again.
    start_round_b(2'd2);
    check("b start score", int'(score_b), 0);
    wait_mole_b(k, j);
    tap_b[k] = 1'b1;
    step();
    check("hit hole cleared", int'(holes_b[k]), 0);
    check("hit score +2", int'(score_b), 2);
    repeat (10) step();
    check("held tap single hit", int'(score_b), 2);
    tap_b = '0;
    step();

    // Expiry timing of the first mole, then miss limit ends the round.
    start_round_b(2'd3);
    wait_mole_b(k, j);
    repeat (4 * LIFE3 - 1) step();
    check("mole up before expiry", int'(holes_b[k]), 1);
    check("no miss before expiry", int'(misses_b), 0);
    step();
    check("mole gone at expiry", int'(holes_b[k]), 0);
    check("first miss", int'(misses_b), 1);
    for (int i = 0; i < 1500; i++) begin
      if (over_b) break;
      step();
    end
    check("miss limit game_over", int'(over_b), 1);
    check("miss limit misses", int'(misses_b), 3);
    check("miss limit holes", int'(holes_b), 0);
    check("miss limit playing", int'(play_b), 0);

    // Hit on the very tick the mole would expire.
    start_round_b(2'd3);
    wait_mole_b(k, j);
    repeat (4 * LIFE3 - 1) step();
    tap_b[k] = 1'b1;
    step();
    check("hit vs expiry hole", int'(holes_b[k]), 0);
    check("hit vs expiry score", int'(score_b), 3);
    check("hit vs expiry misses", int'(misses_b), 0);
    tap_b = '0;
    step();

    // Saturation and penalty sequence on a 4-bit score.
    start_round_b(2'd3);
    check("sat start score", int'(score_b), 0);
    for (int i = 0; i < 8; i++) do_op(i, vecs[i].op, vecs[i].exp_score);

    // Asynchronous reset in mid-play with two moles up.
    two_up = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($countones(holes_b) >= 2) begin
        two_up = 1'b1;
        break;
      end
      step();
    end
    check("two moles up", int'(two_up), 1);
    #2 rst_b_n = 1'b0;
    #1;
    check("async rst holes", int'(holes_b), 0);
    check("async rst score", int'(score_b), 0);
    check("async rst playing", int'(play_b), 0);
    check("async rst misses", int'(misses_b), 0);
    check("async rst lfsr", int'(dut_b.lfsr_q), 'hACE1);
    step();
    rst_b_n = 1'b1;
    step();

    // Empty-hole tap at zero score clamps at zero.
    start_round_b(2'd3);
    tap_b[0] = 1'b1;
    step();
    check("penalty floor", int'(score_b), 0);
    tap_b = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wam_round_engine.md
Name: wam_round_engine

Overview:
- Parametrised successor to the current whack-a-mole top level: one block owns the tick prescaler, LFSR mole spawner, per-hole mole lifetimes, hit detection, saturating score, miss count, round timer and the game state machine.
- Generalised in hole count, score width and timing, with difficulty tables, round time-out, a miss limit, pause freeze and an optional wrong-tap penalty.
- Sits between the debounced switch/button inputs and the display/score drivers.

Parameters:
- N_HOLES, 8, number of holes and tap inputs (2..16)
- SCORE_W, 12, score width; binary, saturating
- DIV_W, 19, prescaler width; one tick per 2^DIV_W clk
- TICKS_PER_SEC, 100, ticks per round-timer decrement
- ROUND_SECS, 60, round length in seconds (timer width TIME_W = clog2(ROUND_SECS+1))
- MAX_MISS, 10, misses that end the round (MISS_W = clog2(MAX_MISS+1))
- PENALTY_EN, 0, 1 = a tap edge on an empty hole subtracts 1 point
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
- clk  in  1  system clock
- clr_n  in  1  asynchronous active-low reset
- start  in  1  start/restart button, level, synchronous, debounced
- pause  in  1  level; freezes play while high
- difficulty  in  2  0 easy .. 3 hard; sampled only at a round start
- tap  in  N_HOLES  hit switches, level
- holes  out  N_HOLES  1 = mole visible
- score  out  SCORE_W  current score
- misses  out  MISS_W  expired moles this round
- time_left  out  TIME_W  seconds remaining
- game_over  out  1  high in OVER
- playing  out  1  high in PLAY

Behaviour:
- Reset (clr_n=0, async): state IDLE; holes, score, misses, time_left, prescaler, spawn counter, all slot counters = 0; LFSR = LFSR_SEED; start/tap edge registers = 0.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, advances every clk in every state including pause; never reaches 0.
- Prescaler: counts every clk except in PAUSED (holds). tick = counter all-ones AND state==PLAY; single-cycle pulse.
- Edges: start_e = start & ~start_q; tap_e[i] = tap[i] & ~tap_q[i]. Edge registers update every cycle in every state, so resuming from pause never produces a stale edge.
- FSM:
  - IDLE -> PLAY on start_e.
  - PLAY -> PAUSED when pause=1; PAUSED -> PLAY when pause=0.
  - PLAY -> OVER on the tick where time_left goes 1->0, or on the cycle misses reaches MAX_MISS.
  - OVER -> PLAY on start_e.
- start_e in PLAY or PAUSED restarts the round; start_e has priority over pause.
- Round start (cycle after start_e): latch difficulty into diff_r; score=0, misses=0, holes=0, time_left=ROUND_SECS, second counter=0, spawn counter=SPAWN[diff_r].
- Difficulty tables, indexed 0..3:
  - SPAWN ticks: 50, 30, 15, 8.
  - LIFE ticks: 150, 100, 60, 35.
  - MAX_ACTIVE: 1, 2, 3, 4 (clamped to N_HOLES).
  - POINTS: 1, 1, 2, 3.
- Spawn: on a tick with spawn counter == 1:
  - Candidate = LFSR[3:0] mod N_HOLES.
  - If the candidate is empty and popcount(holes) < MAX_ACTIVE: candidate slot loads LIFE, hole set.
  - Otherwise no spawn, no retry.
  - Either way the counter reloads SPAWN. On other ticks it decrements.
- Slot (per hole):
  - Active counter decrements on tick.
  - At counter==1 on a tick: hole clears, expire pulse.
  - Hit when tap_e[i] & holes[i]: hole clears next cycle, hit pulse. Hit beats expiry in the same cycle (no miss counted).
- Score: each cycle, sum = score + POINTS*popcount(hit) - (PENALTY_EN ? popcount(tap_e & ~holes) : 0), computed at SCORE_W+5 bits signed; clamp to [0, 2^SCORE_W-1].
- misses += popcount(expire), saturating at MAX_MISS.
- Taps are ignored outside PLAY.
- PAUSED: holes, counters, score and time held; taps ignored.
- OVER: holes = 0; score, misses and time_left held.
- Outputs are all registered; a hit is visible on holes/score one cycle after tap_e.

Decomposition:
- Package wam_pkg: state enum (IDLE, PLAY, PAUSED, OVER); SPAWN/LIFE/MAX_ACTIVE/POINTS tables as constant functions of difficulty; LFSR tap mask.
- Sub-module wam_mole_slot, instantiated N_HOLES times by generate. Ports: clk, clr_n, clear, load, life, tick, tap_e. Outputs: active, hit, expire.

Test Plan:
Simulation parameters: DIV_W=2, TICKS_PER_SEC=4, ROUND_SECS=3, MAX_MISS=3, N_HOLES=8.
- Reset mid-play: clr_n low with 2 moles up -> holes=0, score=0, state IDLE immediately (async); LFSR reads 16'hACE1.
- Timer: start_e, difficulty 0, no taps -> time_left steps 3,2,1,0 every 16 clk; game_over asserts on the 0 tick; holes=0.
- Hit: difficulty 2, mole on hole k, rising tap[k] -> next cycle holes[k]=0, score +2. Tap held high for 10 cycles -> only one hit counted.
- Hit vs expiry: tap_e[k] on the tick where slot k counter==1 -> score +POINTS, misses unchanged. Let 3 moles expire -> OVER when misses=3.
- Pause: pause high for 100 clk in PLAY -> holes, score, time_left unchanged and no taps counted. Release -> timing resumes from the held count.
- Saturation/penalty, with SCORE_W=4 and PENALTY_EN=1:
  - Score at 15 plus a hit -> 15.
  - Score at 0 plus an empty-hole tap -> 0.
  - Simultaneous hit (+3) and empty tap at score 14 -> 15.
